rs_ff_pipeline_tail_fifo: RTL and testbench

//   Tail stage of a pipelined relay-station FIFO link.
//   - Sits at the consumer end of the RS_FF_PP TAIL region, fed by the last BODY register stage.
//   - Absorbs words still in flight when backpressure is asserted.
//   - Emits a registered almost-full (if_full_n), which travels back upstream through the body stages.
//   - Presents a first-word-fall-through (FWFT) FIFO read port to the consumer.

---
 rtl/rs_ff_pkg.sv | 20 ++
 rtl/rs_ff_tail_mem.sv | 23 ++
 rtl/rs_ff_pipeline_tail_fifo.sv | 93 +++++++++
 tb/tb_rs_ff_pipeline_tail_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_ff_pkg.sv
// Shared helpers for the RS_FF_PP relay-station FIFO link.
package rs_ff_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Free slots a tail must keep for words still in flight through the body stages
    function automatic int RS_RESERVE(input int level);
        return 2 * level + 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/rs_ff_tail_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module rs_ff_tail_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rs_ff_pipeline_tail_fifo.sv
// Tail stage of a pipelined relay-station FIFO: FWFT read port, registered almost-full.
// Optional macro RS_TAIL_OCCUPANCY_EN adds occupancy and peak outputs.
module rs_ff_pipeline_tail_fifo
    import rs_ff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_LEVEL = 6,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic                  overflow
`ifdef RS_TAIL_OCCUPANCY_EN
    ,
    output logic [clog2(DEPTH):0] occupancy,
    output logic [clog2(DEPTH):0] peak
`endif
);

    localparam int RESERVE = RS_RESERVE(PIPE_LEVEL);
    localparam int AW      = ptr_width(DEPTH);
    localparam int CW      = clog2(DEPTH) + 1;

    if (DEPTH < RESERVE + 2) begin : g_depth_check
        $error("rs_ff_pipeline_tail_fifo: DEPTH must be >= RESERVE+2");
    end
    if ((1 << clog2(DEPTH)) != DEPTH) begin : g_pow2_check
        $error("rs_ff_pipeline_tail_fifo: DEPTH must be a power of two");
    end

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_next;
    logic                  push, pop, full;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        full       = (count == CW'(DEPTH));
        if_empty_n = (count != '0);
        pop        = if_read & if_empty_n;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
        push       = if_write & (~full | pop);
        count_next = count + CW'(push) - CW'(pop);
        if_dout    = if_empty_n ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            if_full_n <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            if_full_n <= (count_next <= CW'(DEPTH - RESERVE));
            if (if_write & full & ~pop) overflow <= 1'b1;
        end
    end

    rs_ff_tail_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (if_din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

`ifdef RS_TAIL_OCCUPANCY_EN
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  peak_q <= '0;
        else if (count_next > peak_q) peak_q <= count_next;
    end

    assign occupancy = count;
    assign peak      = peak_q;
`endif

endmodule

// File: tb/tb_rs_ff_pipeline_tail_fifo.sv
// Self-checking bench for rs_ff_pipeline_tail_fifo (DEPTH=32, PIPE_LEVEL=6).
module tb_rs_ff_pipeline_tail_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int THRESH = 18;   // DEPTH - (2*6+2)

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] if_din;
    logic          if_write;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          if_read;
    logic          overflow;
`ifdef RS_TAIL_OCCUPANCY_EN
    logic [5:0]    occupancy;
    logic [5:0]    peak;
`endif

    rs_ff_pipeline_tail_fifo #(
        .DATA_WIDTH (DW),
        .PIPE_LEVEL (6),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_din     (if_din),
        .if_write   (if_write),
        .if_full_n  (if_full_n),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .overflow   (overflow)
`ifdef RS_TAIL_OCCUPANCY_EN
        ,
        .occupancy  (occupancy),
        .peak       (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        logic          exp_empty_n;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t          vecs [12];
    logic [DW-1:0] q [$];
    logic          exp_ovf;
    int            peak_model;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_write = 1'b0;
        if_read  = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        q.delete();
        exp_ovf    = 1'b0;
        peak_model = 0;
    endtask

    initial begin
        // Vectors: each row is applied, one edge taken, then outputs compared
        vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 32'h11};
        vecs[1]  = '{1'b1, 32'h12, 1'b0, 1'b1, 32'h11};
        vecs[2]  = '{1'b1, 32'h13, 1'b0, 1'b1, 32'h11};
        vecs[3]  = '{1'b1, 32'h14, 1'b0, 1'b1, 32'h11};
        vecs[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h12};
        vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h13};
        vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h14};
        vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00};
        vecs[9]  = '{1'b1, 32'hAA, 1'b1, 1'b1, 32'hAA};
        vecs[10] = '{1'b1, 32'hBB, 1'b1, 1'b1, 32'hBB};
        vecs[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00};

        // Test 1: reset then idle
        rst_n    = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        #3;
        check("rst_empty_n", if_empty_n, 0);
        check("rst_full_n", if_full_n, 0);
        check("rst_dout", if_dout, 0);
        check("rst_overflow", overflow, 0);
        tick();
        check("rst_full_n_edge", if_full_n, 0);
        rst_n = 1'b1;
        check("release_full_n_before_edge", if_full_n, 0);
        tick();
        check("release_full_n", if_full_n, 1);
        check("idle_empty_n", if_empty_n, 0);
        check("idle_dout", if_dout, 0);

        // Test 2: table-driven write/read sequence
        for (int i = 0; i < 12; i++) begin
            if_write = vecs[i].wr;
            if_din   = vecs[i].din;
            if_read  = vecs[i].rd;
            tick();
            check($sformatf("vec%0d_empty_n", i), if_empty_n, vecs[i].exp_empty_n);
            check($sformatf("vec%0d_dout", i), if_dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_full_n", i), if_full_n, 1);
        end
        if_write = 1'b0;
        if_read  = 1'b0;

        // Test 3: fill with continuous writes, almost-full threshold, in-flight absorption
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if_write = 1'b1;
            if_din   = 32'h100 + i;
            tick();
            q.push_back(32'h100 + i);
            check($sformatf("fill%0d_full_n", q.size()), if_full_n, (q.size() <= THRESH));
            check($sformatf("fill%0d_overflow", q.size()), overflow, 0);
        end
        check("fill_head", if_dout, 32'h100);

        // Test 4: full with simultaneous write and read
        check("full_rw_head_before", if_dout, q[0]);
        if_write = 1'b1;
        if_read  = 1'b1;
        if_din   = 32'h200;
        tick();
        void'(q.pop_front());
        q.push_back(32'h200);
        check("full_rw_head_after", if_dout, q[0]);
        check("full_rw_overflow", overflow, 0);
        check("full_rw_full_n", if_full_n, 0);
`ifdef RS_TAIL_OCCUPANCY_EN
        check("full_rw_occupancy", occupancy, 32);
        check("full_rw_peak", peak, 32);
`endif

        // Test 5: write into a truly full FIFO, sticky overflow, drain in order
        if_read = 1'b0;
        if_din  = 32'h300;
        tick();
        check("ovf_set", overflow, 1);
        if_write = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d_dout", i), if_dout, q[0]);
            if_read = 1'b1;
            tick();
            void'(q.pop_front());
            check($sformatf("drain%0d_ovf", i), overflow, 1);
        end
        if_read = 1'b0;
        check("drain_empty_n", if_empty_n, 0);
        check("drain_full_n", if_full_n, 1);
        do_reset();
        check("ovf_cleared", overflow, 0);

        // Test 6: random push/pop against a scoreboard with an async reset mid-stream
        for (int c = 0; c < 220; c++) begin
            logic          w, r, pp, ps;
            logic [DW-1:0] d;
            if (c == 110) begin
                if_write = 1'b0;
                if_read  = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("async_rst_empty_n", if_empty_n, 0);
                check("async_rst_dout", if_dout, 0);
                check("async_rst_full_n", if_full_n, 0);
                q.delete();
                exp_ovf    = 1'b0;
                peak_model = 0;
                tick();
                rst_n = 1'b1;
                tick();
                check("async_rel_full_n", if_full_n, 1);
            end
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) != 0);
            d = $urandom;
            if_write = w;
            if_read  = r;
            if_din   = d;
            tick();
            pp = r && (q.size() != 0);
            ps = w && ((q.size() < DEPTH) || pp);
            if (w && (q.size() == DEPTH) && !pp) exp_ovf = 1'b1;
            if (pp) void'(q.pop_front());
            if (ps) q.push_back(d);
            if (q.size() > peak_model) peak_model = q.size();
            check("rnd_empty_n", if_empty_n, (q.size() != 0));
            check("rnd_dout", if_dout, (q.size() != 0) ? q[0] : 32'h0);
            check("rnd_full_n", if_full_n, (q.size() <= THRESH));
            check("rnd_overflow", overflow, exp_ovf);
`ifdef RS_TAIL_OCCUPANCY_EN
            check("rnd_occupancy", occupancy, q.size());
            check("rnd_peak", peak, peak_model);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
